// File: rtl/zeroriscy_mem_arb.sv
// Two-master (fetch m0 / data m1) arbiter onto one single-port SRAM slave, with an
// in-order owner FIFO for response routing. Optional counters: ZERORISCY_ARB_PERF_EN.
module zeroriscy_mem_arb #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_err
`ifdef ZERORISCY_ARB_PERF_EN
    ,
    output logic [31:0] perf_conflict,
    output logic [31:0] perf_full_stall
`endif
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [OUTSTANDING-1:0] r_owner;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic [SW-1:0]          r_starve;

    logic w_empty;
    logic w_full;
    logic w_any;
    logic w_starved;
    logic w_sel;
    logic w_push;
    logic w_pop;
    logic w_head;

    // Arbitration and FIFO status; a pop this cycle frees a slot for a same-cycle grant.
    always_comb begin
        w_empty   = (r_count == {CW{1'b0}});
        w_full    = (r_count == FULL_CNT) & ~s_rvalid;
        w_any     = m0_req | m1_req;
        w_starved = (r_starve >= STARVE_MAX);
        // m0 is only forced through while it is actually requesting
        w_sel     = m1_req & ~(m0_req & w_starved);
        s_req     = w_any & ~w_full;
        w_push    = s_req & s_gnt;
        w_pop     = s_rvalid & ~w_empty;
        w_head    = r_owner[r_rptr];
    end

    // Slave command mux and grant decode.
    always_comb begin
        s_we    = 1'b0;
        s_be    = 4'hF;
        s_addr  = m0_addr;
        s_wdata = 32'h0000_0000;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        if (w_sel) begin
            s_we    = m1_we;
            s_be    = m1_be;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            m1_gnt  = w_push;
        end else begin
            m0_gnt  = w_push;
        end
    end

    // Response routing by the owner at the FIFO head; responses with no owner are dropped.
    always_comb begin
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        if (w_pop) begin
            m0_rvalid = ~w_head;
            m1_rvalid = w_head;
        end else begin
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
        end
        m1_err = s_err & m1_rvalid;
    end

    // Owner FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= {OUTSTANDING{1'b0}};
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_sel;
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of consecutive cycles m0 has been refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= {SW{1'b0}};
        end else if (m0_req & ~m0_gnt) begin
            if (!w_starved) begin
                r_starve <= r_starve + SW'(1);
            end
        end else begin
            r_starve <= {SW{1'b0}};
        end
    end

`ifdef ZERORISCY_ARB_PERF_EN
    logic [31:0] r_perf_conflict;
    logic [31:0] r_perf_full_stall;

    // Wrapping event counters for contention and back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_conflict   <= 32'h0000_0000;
            r_perf_full_stall <= 32'h0000_0000;
        end else begin
            if (m0_req & m1_req & ~w_full) begin
                r_perf_conflict <= r_perf_conflict + 32'd1;
            end
            if (w_any & w_full) begin
                r_perf_full_stall <= r_perf_full_stall + 32'd1;
            end
        end
    end

    assign perf_conflict   = r_perf_conflict;
    assign perf_full_stall = r_perf_full_stall;
`endif

endmodule
